// File: rtl/signed_serial_pkg.sv
// Shared defaults and state encoding for the signed serial link.
// No logic of its own; used by the receiver and its sign-extension helper.
// No flow control here.
package signed_serial_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int EXT_WIDTH_DEF = 16;

    // Receiver frame state: waiting for a start bit, or collecting bits.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

    // Bits needed to count 0..value-1 (value >= 2).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/signed_serial_rx_sign_ext.sv
// Widens a raw word with sign or zero extension depending on its signedness tag.
// Purely combinational, zero latency.
// No backpressure; output follows inputs.
module sign_ext_unit #(
    parameter int WIDTH     = 8,
    parameter int EXT_WIDTH = 16
) (
    input  logic [WIDTH-1:0]     raw,
    input  logic                 is_signed,
    output logic [EXT_WIDTH-1:0] ext
);

    // Replicate the MSB only for signed words; unsigned words get zeros.
    always_comb begin
        ext = {{(EXT_WIDTH - WIDTH){is_signed & raw[WIDTH-1]}}, raw};
    end

endmodule

// File: rtl/signed_serial_rx.sv
// Deserialises LSB-first frames into raw and sign/zero-extended words.
// out_valid rises the cycle after the last bit; next frame shifts while a word is held.
// Single-entry output: a word completing while the register is full and not read is dropped.
module signed_serial_rx
    import signed_serial_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int EXT_WIDTH = EXT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sin_valid,
    input  logic                 sin_bit,
    input  logic                 sin_start,
    input  logic                 sin_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_raw,
    output logic [EXT_WIDTH-1:0] out_ext,
    output logic                 out_is_signed,
    output logic                 out_neg,
    output logic                 frame_err,
    output logic                 overrun_err,
    input  logic                 err_clr
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]      shreg_q, shreg_d;
    logic                  sgn_q, sgn_d;
    logic                  complete;
    logic                  frame_err_set;

    logic                  out_valid_q;
    logic [WIDTH-1:0]      out_raw_q;
    logic [EXT_WIDTH-1:0]  out_ext_q;
    logic                  out_is_signed_q;
    logic                  out_neg_q;
    logic                  frame_err_q;
    logic                  overrun_err_q;

    logic                  load;
    logic                  overrun_set;
    logic [EXT_WIDTH-1:0]  ext_w;

    // Frame FSM: next state, bit counter, shift register and completion strobe.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        sgn_d         = sgn_q;
        complete      = 1'b0;
        frame_err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (sin_valid && sin_start) begin
                    shreg_d = {{(WIDTH-1){1'b0}}, sin_bit};
                    sgn_d   = sin_signed;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sin_valid && sin_start) begin
                    // Early start: abandon the partial word and restart at bit 0.
                    frame_err_set = 1'b1;
                    shreg_d       = {{(WIDTH-1){1'b0}}, sin_bit};
                    sgn_d         = sin_signed;
                    cnt_d         = CW'(1);
                end else if (sin_valid) begin
                    shreg_d[cnt_q] = sin_bit;
                    if (cnt_q == LAST_BIT) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The register accepts a new word when empty or being drained this cycle.
    assign load        = complete & (~out_valid_q | out_ready);
    assign overrun_set = complete & ~load;

    sign_ext_unit #(
        .WIDTH     (WIDTH),
        .EXT_WIDTH (EXT_WIDTH)
    ) u_sign_ext (
        .raw       (shreg_d),
        .is_signed (sgn_d),
        .ext       (ext_w)
    );

    // Frame state registers; reset drops any partial frame silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            sgn_q   <= sgn_d;
        end
    end

    // Output register: load completed word, otherwise hold until handshake clears valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            out_raw_q       <= '0;
            out_ext_q       <= '0;
            out_is_signed_q <= 1'b0;
            out_neg_q       <= 1'b0;
        end else if (load) begin
            out_valid_q     <= 1'b1;
            out_raw_q       <= shreg_d;
            out_ext_q       <= ext_w;
            out_is_signed_q <= sgn_d;
            out_neg_q       <= sgn_d & shreg_d[WIDTH-1];
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Sticky error flags; a fresh error beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            if (frame_err_set) begin
                frame_err_q <= 1'b1;
            end else if (err_clr) begin
                frame_err_q <= 1'b0;
            end
            if (overrun_set) begin
                overrun_err_q <= 1'b1;
            end else if (err_clr) begin
                overrun_err_q <= 1'b0;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_raw       = out_raw_q;
    assign out_ext       = out_ext_q;
    assign out_is_signed = out_is_signed_q;
    assign out_neg       = out_neg_q;
    assign frame_err     = frame_err_q;
    assign overrun_err   = overrun_err_q;

endmodule

// File: tb/tb_signed_serial_rx.sv
// Directed plus randomized bench for signed_serial_rx.
// Expected words come from an arithmetic signed-value model.
// Exercises holding, overrun, early start, reset and stalls.
module tb_signed_serial_rx;

    localparam int W  = 8;
    localparam int EW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          sin_valid;
    logic          sin_bit;
    logic          sin_start;
    logic          sin_signed;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_raw;
    logic [EW-1:0] out_ext;
    logic          out_is_signed;
    logic          out_neg;
    logic          frame_err;
    logic          overrun_err;
    logic          err_clr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    signed_serial_rx #(.WIDTH(W), .EXT_WIDTH(EW)) dut (
        .clk           (clk),
        .rst           (rst),
        .sin_valid     (sin_valid),
        .sin_bit       (sin_bit),
        .sin_start     (sin_start),
        .sin_signed    (sin_signed),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_raw       (out_raw),
        .out_ext       (out_ext),
        .out_is_signed (out_is_signed),
        .out_neg       (out_neg),
        .frame_err     (frame_err),
        .overrun_err   (overrun_err),
        .err_clr       (err_clr)
    );

    // Numeric value of the word, reduced modulo 2**EW.
    function automatic logic [EW-1:0] model_ext(input logic [W-1:0] raw, input bit sgn);
        int v;
        v = int'(raw);
        if (sgn && v >= (1 << (W - 1))) v = v - (1 << W);
        return EW'(v);
    endfunction

    function automatic bit model_neg(input logic [W-1:0] raw, input bit sgn);
        return sgn && (int'(raw) >= (1 << (W - 1)));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends the first nbits of a frame; stall_pct inserts idle cycles with junk on the data lines.
    task automatic send_bits(input logic [W-1:0] raw, input bit sgn, input int nbits, input int stall_pct);
        for (int i = 0; i < nbits; i++) begin
            while ($urandom_range(99) < stall_pct) begin
                sin_valid  = 1'b0;
                sin_bit    = 1'($urandom);
                sin_start  = 1'($urandom);
                sin_signed = 1'($urandom);
                tick();
            end
            sin_valid  = 1'b1;
            sin_bit    = raw[i];
            sin_start  = (i == 0);
            sin_signed = sgn;
            tick();
        end
        sin_valid = 1'b0;
        sin_start = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [W-1:0] raw, input bit sgn);
        check({tag, ".valid"},  32'(out_valid), 32'd1);
        check({tag, ".raw"},    32'(out_raw), 32'(raw));
        check({tag, ".ext"},    32'(out_ext), 32'(model_ext(raw, sgn)));
        check({tag, ".signed"}, 32'(out_is_signed), 32'(sgn));
        check({tag, ".neg"},    32'(out_neg), 32'(model_neg(raw, sgn)));
    endtask

    logic [W-1:0] exp_q[$];
    bit           sgn_q[$];
    logic [W-1:0] r;
    bit           s;
    int           words;

    initial begin
        rst = 1'b1; sin_valid = 1'b0; sin_bit = 1'b0; sin_start = 1'b0;
        sin_signed = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        tick(); tick();
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.raw", 32'(out_raw), 32'd0);
        check("rst.ext", 32'(out_ext), 32'd0);
        check("rst.errs", {30'd0, frame_err, overrun_err}, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        // Basic signed/unsigned words.
        send_bits(8'h85, 1'b1, W, 0);
        check_word("s85", 8'h85, 1'b1);
        check("s85.ext_lit", 32'(out_ext), 32'hFF85);
        tick();
        check("s85.drain", 32'(out_valid), 32'd0);
        send_bits(8'h85, 1'b0, W, 0);
        check_word("u85", 8'h85, 1'b0);
        check("u85.ext_lit", 32'(out_ext), 32'h0085);
        send_bits(8'h7F, 1'b1, W, 0);
        check_word("s7f", 8'h7F, 1'b1);
        tick();

        // Hold and overrun.
        out_ready = 1'b0;
        send_bits(8'h12, 1'b0, W, 0);
        check_word("hold12", 8'h12, 1'b0);
        check("hold12.ovr", 32'(overrun_err), 32'd0);
        send_bits(8'h34, 1'b0, W, 0);
        check_word("ovr.kept", 8'h12, 1'b0);
        check("ovr.flag", 32'(overrun_err), 32'd1);
        out_ready = 1'b1;
        tick();
        check("ovr.drained", 32'(out_valid), 32'd0);
        tick();
        check("ovr.no34", 32'(out_valid), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovr.clr", 32'(overrun_err), 32'd0);

        // Early start aborts a partial frame.
        send_bits(8'h5A, 1'b0, 3, 0);
        check("ferr.pre", 32'(frame_err), 32'd0);
        send_bits(8'h80, 1'b1, W, 0);
        check_word("ferr80", 8'h80, 1'b1);
        check("ferr80.ext_lit", 32'(out_ext), 32'hFF80);
        check("ferr.flag", 32'(frame_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ferr.clr", 32'(frame_err), 32'd0);

        // Reset mid-frame, with a word held in the output register.
        out_ready = 1'b0;
        send_bits(8'hC3, 1'b1, W, 0);
        send_bits(8'hFF, 1'b1, 5, 0);
        rst = 1'b1;
        tick();
        check("mrst.valid", 32'(out_valid), 32'd0);
        check("mrst.raw", 32'(out_raw), 32'd0);
        check("mrst.ext", 32'(out_ext), 32'd0);
        check("mrst.flags", {28'd0, out_is_signed, out_neg, frame_err, overrun_err}, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        send_bits(8'hA5, 1'b0, W, 0);
        check_word("a5", 8'hA5, 1'b0);
        check("a5.ext_lit", 32'(out_ext), 32'h00A5);
        check("a5.errs", {30'd0, frame_err, overrun_err}, 32'd0);
        tick();

        // Ten back-to-back random frames, continuous sin_valid.
        words = 0;
        for (int f = 0; f < 10; f++) begin
            r = W'($urandom);
            s = 1'($urandom);
            for (int i = 0; i < W; i++) begin
                sin_valid  = 1'b1;
                sin_bit    = r[i];
                sin_start  = (i == 0);
                sin_signed = s;
                if (i == W - 1) begin
                    exp_q.push_back(r);
                    sgn_q.push_back(s);
                end
                tick();
                check("b2b.valid_timing", 32'(out_valid), 32'(i == W - 1));
                if (out_valid && exp_q.size() > 0) begin
                    check_word("b2b", exp_q.pop_front(), sgn_q.pop_front());
                    words++;
                end
            end
        end
        sin_valid = 1'b0;
        sin_start = 1'b0;
        check("b2b.count", 32'(words), 32'd10);
        check("b2b.errs", {30'd0, frame_err, overrun_err}, 32'd0);
        tick();

        // Random frames with random stalls between bits.
        for (int f = 0; f < 20; f++) begin
            r = W'($urandom);
            s = 1'($urandom);
            send_bits(r, s, W, 40);
            check_word("rnd", r, s);
            tick();
            check("rnd.drain", 32'(out_valid), 32'd0);
        end
        check("rnd.errs", {30'd0, frame_err, overrun_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/signed_serial_rx.md
Name: signed_serial_rx

Overview:
- Receive end of the bit-serial sample link. Deserialises LSB-first WIDTH-bit words and tags each word as signed or unsigned.
- Delivers each word both raw and extended to EXT_WIDTH, with correct sign or zero extension.
- Sits between the serial sample link and consumers that need explicit signedness at the port, e.g. arithmetic or compare units.
- Single-entry output register with valid/ready handshake; shifting of the next frame overlaps with output hold.

Parameters:
- WIDTH, 8, serial word length in bits (>= 2).
- EXT_WIDTH, 16, width of extended output (> WIDTH).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- sin_valid  in  1  serial bit strobe; sin_bit/sin_start/sin_signed meaningful only when high.
- sin_bit  in  1  serial data bit, LSB first.
- sin_start  in  1  marks first bit of a frame (qualified by sin_valid).
- sin_signed  in  1  frame signedness; sampled only with the start bit.
- out_valid  out  1  output word available.
- out_ready  in  1  consumer accepts word when out_valid & out_ready.
- out_raw  out  WIDTH  received word, unsigned view.
- out_ext  out  EXT_WIDTH  signed; sign-extended if frame signed, else zero-extended.
- out_is_signed  out  1  frame signedness flag.
- out_neg  out  1  out_is_signed & out_raw[WIDTH-1].
- frame_err  out  1  sticky: frame aborted by an early sin_start.
- overrun_err  out  1  sticky: completed word dropped because the output register was full.
- err_clr  in  1  clears both sticky errors; a new error in the same cycle wins.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset: all outputs 0, FSM IDLE, bit counter 0, shift register 0. A reset mid-frame discards the partial frame without flagging an error.
- FSM states: IDLE, SHIFT.
  - IDLE: sin_valid & sin_start -> load bit 0, latch sin_signed, cnt=1, go to SHIFT. sin_valid without sin_start is ignored; no error.
  - SHIFT: each sin_valid & !sin_start stores sin_bit at position cnt, then cnt++.
  - SHIFT, cnt==WIDTH-1 with a valid bit: frame completes; return to IDLE.
  - SHIFT, sin_valid & sin_start: set frame_err, discard the partial frame, restart at bit 0 with the new sin_signed. Stay in SHIFT, cnt=1.
  - sin_valid low stalls the frame indefinitely; no timeout.
- Completion:
  - On the cycle the last bit is accepted, the word is written to the output register if the register is empty or being consumed that cycle (out_valid & out_ready).
  - Latency: out_valid rises on the cycle after the last bit is accepted.
  - Otherwise the completed word is dropped, overrun_err is set, and the held word is preserved unchanged.
- Output register:
  - out_* stay stable while out_valid & !out_ready.
  - out_valid clears the cycle after a handshake unless a new word loads that same cycle. Back-to-back frames give continuous throughput of one word per WIDTH sin_valid cycles.
- Extension: out_ext = {(EXT_WIDTH-WIDTH){is_signed & msb}, raw}. Computed at load time and registered with out_raw.
- A start bit arriving on the same cycle as a frame completion cannot occur, since completion consumes the valid bit. A start bit on the cycle after completion begins a new frame normally.

Decomposition:
- Package signed_serial_pkg: WIDTH/EXT_WIDTH defaults, FSM state encoding (IDLE=0, SHIFT=1), counter width function clog2(WIDTH).
- One sub-module, sign_ext_unit: combinational; inputs raw[WIDTH] and is_signed, output ext[EXT_WIDTH]. Reused by the matching transmitter's checker.
- The rest (FSM, counter, shift register, output register, error flags) stays in signed_serial_rx.

Test Plan:
- Signed frame 0x85 (bits 1,0,1,0,0,0,0,1), out_ready=1 -> one cycle after the last bit: out_raw=0x85, out_ext=0xFF85, out_is_signed=1, out_neg=1.
- Same bits with sin_signed=0 -> out_ext=0x0085, out_neg=0; signed 0x7F -> out_ext=0x007F, out_neg=0.
- out_ready=0; send 0x12 then 0x34 -> out_raw holds 0x12, overrun_err=1. Raise out_ready -> 0x12 accepted, out_valid=0 next cycle, 0x34 never appears.
- Send 3 bits, then sin_start with signed frame 0x80 -> frame_err=1, output 0x80/0xFF80. Pulse err_clr -> frame_err=0.
- Reset asserted after 5 bits of a frame -> all outputs 0 the next cycle. A following full frame 0xA5 (unsigned) -> out_ext=0x00A5, no errors.
- Ten back-to-back frames with sin_valid continuous, out_ready=1 -> ten words in order, one every 8 cycles, no errors.
